program_loader: RTL and testbench

PROGRAM_LOADER -- requirements
Module: program_loader

---
 rtl/program_loader_if.sv | 25 ++
 rtl/program_loader.sv | 150 +++++++++++++++
 tb/tb_program_loader.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/program_loader_if.sv
// Load-stream and memory-write bundle between the stream source and program_loader.
// master: stream source / observer side; slave: the loader.
interface program_loader_if #(
    parameter int word_size = 8
);
    logic [word_size-1:0] in_data;
    logic                 in_valid;
    logic                 in_ready;
    logic                 mem_we;
    logic [word_size-1:0] mem_addr;
    logic [word_size-1:0] mem_data;
    logic                 cpu_rst;
    logic                 done;
    logic                 error;

    modport master (
        output in_data, in_valid,
        input  in_ready, mem_we, mem_addr, mem_data, cpu_rst, done, error
    );

    modport slave (
        input  in_data, in_valid,
        output in_ready, mem_we, mem_addr, mem_data, cpu_rst, done, error
    );
endinterface

// File: rtl/program_loader.sv
// Program loader: parses ADDR/LEN/DATA[/CHECKSUM] records from a byte stream,
// writes the data bytes into program memory and releases the CPU reset once a
// zero-length terminator record has been accepted.
// Optional feature: define LOADER_CHECKSUM_EN to expect and verify a trailing
// checksum byte per record (8-bit sum of all record bytes must be zero).
//
// state  | meaning
// S_ADDR | waiting for the record start address
// S_LEN  | waiting for the record length
// S_DATA | receiving data bytes, one memory write per byte
// S_CSUM | waiting for the record checksum (checksum builds only)
// S_DONE | terminator accepted, CPU released; left only by rst
// S_ERR  | checksum mismatch, stream halted, CPU held in reset
module program_loader #(
    parameter int word_size = 8
) (
    input logic          clk,
    input logic          rst,
    program_loader_if.slave bus
);
    typedef enum logic [2:0] {
        S_ADDR,
        S_LEN,
        S_DATA,
`ifdef LOADER_CHECKSUM_EN
        S_CSUM,
`endif
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [word_size-1:0] ONE = {{(word_size-1){1'b0}}, 1'b1};

    state_t               state_q, state_d;
    logic [word_size-1:0] ptr_q, ptr_d;
    logic [word_size-1:0] cnt_q, cnt_d;
    logic                 mem_we_q, mem_we_d;
    logic [word_size-1:0] mem_addr_q, mem_addr_d;
    logic [word_size-1:0] mem_data_q, mem_data_d;
    logic                 accept;
`ifdef LOADER_CHECKSUM_EN
    logic [word_size-1:0] sum_q, sum_d;
    logic [word_size-1:0] sum_next;
    logic                 term_q, term_d;
`endif

    // Handshake and status outputs decode directly from the current state.
    always_comb begin
        bus.in_ready = (state_q != S_DONE) && (state_q != S_ERR);
        bus.done     = (state_q == S_DONE);
        bus.cpu_rst  = (state_q == S_DONE);
`ifdef LOADER_CHECKSUM_EN
        bus.error    = (state_q == S_ERR);
`else
        bus.error    = 1'b0;
`endif
        bus.mem_we   = mem_we_q;
        bus.mem_addr = mem_addr_q;
        bus.mem_data = mem_data_q;
        accept       = bus.in_valid && bus.in_ready;
    end

    // Record parser: next state, write pointer, remaining-byte counter, write strobe.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
        mem_we_d   = 1'b0;
        mem_addr_d = mem_addr_q;
        mem_data_d = mem_data_q;
`ifdef LOADER_CHECKSUM_EN
        sum_d      = sum_q;
        term_d     = term_q;
        sum_next   = sum_q + bus.in_data;
`endif
        if (accept) begin
`ifdef LOADER_CHECKSUM_EN
            sum_d = sum_next;
`endif
            case (state_q)
                S_ADDR: begin
                    ptr_d   = bus.in_data;
                    state_d = S_LEN;
                end
                S_LEN: begin
                    cnt_d = bus.in_data;
`ifdef LOADER_CHECKSUM_EN
                    term_d  = (bus.in_data == '0);
                    state_d = (bus.in_data == '0) ? S_CSUM : S_DATA;
`else
                    state_d = (bus.in_data == '0) ? S_DONE : S_DATA;
`endif
                end
                S_DATA: begin
                    mem_we_d   = 1'b1;
                    mem_addr_d = ptr_q;
                    mem_data_d = bus.in_data;
                    ptr_d      = ptr_q + ONE;
                    cnt_d      = cnt_q - ONE;
                    if (cnt_q == ONE) begin
`ifdef LOADER_CHECKSUM_EN
                        state_d = S_CSUM;
`else
                        state_d = S_ADDR;
`endif
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                S_CSUM: begin
                    // Clear the accumulator so the next record starts from zero.
                    sum_d = '0;
                    if (sum_next != '0) begin
                        state_d = S_ERR;
                    end else begin
                        state_d = term_q ? S_DONE : S_ADDR;
                    end
                end
`endif
                default: state_d = state_q;
            endcase
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_ADDR;
            ptr_q      <= '0;
            cnt_q      <= '0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
`ifdef LOADER_CHECKSUM_EN
            sum_q      <= '0;
            term_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
            mem_we_q   <= mem_we_d;
            mem_addr_q <= mem_addr_d;
            mem_data_q <= mem_data_d;
`ifdef LOADER_CHECKSUM_EN
            sum_q      <= sum_d;
            term_q     <= term_d;
`endif
        end
    end
endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: a stream-level record parser predicts which bytes
// produce writes and when the load terminates; one negedge process compares the
// DUT outputs against those predictions every cycle, and literal memory
// contents pin the expected load results.
module tb_program_loader;
    typedef logic [7:0] byte_q_t[$];

    localparam int K_HDR  = 0;
    localparam int K_DATA = 1;
    localparam int K_TERM = 2;
    localparam int K_ERR  = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;

    program_loader_if #(.word_size(8)) bus ();

    program_loader #(.word_size(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    bit       chk_en  = 1'b0;
    bit       exp_we  = 1'b0;
    bit       exp_done = 1'b0;
    bit       exp_err = 1'b0;
    logic [7:0] exp_addr = 8'h00;
    logic [7:0] exp_data = 8'h00;

    int         kinds[$];
    logic [7:0] wq_addr[$];
    logic [7:0] wq_data[$];
    logic [7:0] dut_mem[256];
    int         we_count = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Classify every byte of a stream and list the memory writes it must cause.
    task automatic model_parse(input byte_q_t s);
        int i;
        int n;
        int a;
        int l;
        int sum;
        kinds.delete();
        wq_addr.delete();
        wq_data.delete();
        n = s.size();
        for (int k = 0; k < n; k++) kinds.push_back(K_HDR);
        i = 0;
        while (i + 1 < n) begin
            a   = int'(s[i]);
            l   = int'(s[i+1]);
            sum = a + l;
            for (int j = 0; j < l && (i + 2 + j) < n; j++) begin
                kinds[i+2+j] = K_DATA;
                wq_addr.push_back(8'((a + j) % 256));
                wq_data.push_back(s[i+2+j]);
                sum += int'(s[i+2+j]);
            end
`ifdef LOADER_CHECKSUM_EN
            if (i + 2 + l < n) begin
                sum += int'(s[i+2+l]);
                if (sum % 256 != 0) begin
                    kinds[i+2+l] = K_ERR;
                    break;
                end else if (l == 0) begin
                    kinds[i+2+l] = K_TERM;
                    break;
                end
            end
            i = i + 3 + l;
`else
            if (l == 0) begin
                kinds[i+1] = K_TERM;
                break;
            end
            i = i + 2 + l;
`endif
        end
    endtask

    // Every cycle: outputs against the stream-level expectations.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("mem_we",   32'(bus.mem_we),   32'(exp_we));
            chk("mem_addr", 32'(bus.mem_addr), 32'(exp_addr));
            chk("mem_data", 32'(bus.mem_data), 32'(exp_data));
            chk("done",     32'(bus.done),     32'(exp_done));
            chk("cpu_rst",  32'(bus.cpu_rst),  32'(exp_done));
            chk("error",    32'(bus.error),    32'(exp_err));
            chk("in_ready", 32'(bus.in_ready), 32'(!(exp_done || exp_err)));
            if (bus.mem_we === 1'b1) begin
                dut_mem[bus.mem_addr] = bus.mem_data;
                we_count++;
            end
        end
    end

    task automatic step(input bit v, input logic [7:0] d, output bit acc);
        @(negedge clk);
        bus.in_valid = v;
        bus.in_data  = d;
        acc = v && (bus.in_ready === 1'b1);
        @(posedge clk);
        #1;
        exp_we = 1'b0;
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int c = 0; c < n; c++) step(1'b0, 8'h00, acc);
    endtask

    task automatic send(input byte_q_t s, input bit stall);
        bit acc;
        bit tog;
        int guard;
        tog = 1'b1;
        model_parse(s);
        for (int i = 0; i < s.size(); i++) begin
            acc   = 1'b0;
            guard = 0;
            while (!acc && guard < 16) begin
                step(stall ? tog : 1'b1, s[i], acc);
                tog = ~tog;
                guard++;
            end
            if (!acc) begin
                errors++;
                checks++;
                $display("FAIL accept_timeout: byte %0d not accepted within 16 cycles", i);
                break;
            end
            if (kinds[i] == K_DATA) begin
                exp_we   = 1'b1;
                exp_addr = wq_addr.pop_front();
                exp_data = wq_data.pop_front();
            end else if (kinds[i] == K_TERM) begin
                exp_done = 1'b1;
            end else if (kinds[i] == K_ERR) begin
                exp_err = 1'b1;
            end
        end
        chk("writes_pending", 32'(wq_addr.size()), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        exp_we = 1'b0; exp_addr = 8'h00; exp_data = 8'h00;
        exp_done = 1'b0; exp_err = 1'b0;
        wq_addr.delete(); wq_data.delete();
        chk_en = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic clear_mem();
        for (int k = 0; k < 256; k++) dut_mem[k] = 8'h00;
        we_count = 0;
    endtask

    task automatic check_program();
        chk("mem[00]", 32'(dut_mem[8'h00]), 32'h51);
        chk("mem[01]", 32'(dut_mem[8'h01]), 32'h81);
        chk("mem[02]", 32'(dut_mem[8'h02]), 32'h53);
        chk("mem[03]", 32'(dut_mem[8'h03]), 32'h80);
        chk("mem[04]", 32'(dut_mem[8'h04]), 32'hB7);
        chk("mem[80]", 32'(dut_mem[8'h80]), 32'h01);
        chk("mem[81]", 32'(dut_mem[8'h81]), 32'h02);
        chk("mem[82]", 32'(dut_mem[8'h82]), 32'h03);
        chk("mem[8B]", 32'(dut_mem[8'h8B]), 32'hF0);
        chk("mem[8C]", 32'(dut_mem[8'h8C]), 32'h09);
        chk("write_count", 32'(we_count), 32'd10);
    endtask

    initial begin
        byte_q_t prog;
        byte_q_t s;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        clear_mem();
        do_reset();
        chk("reset_in_ready", 32'(bus.in_ready), 32'd1);
        chk("reset_cpu_rst",  32'(bus.cpu_rst),  32'd0);
        chk("reset_mem_we",   32'(bus.mem_we),   32'd0);
        idle(2);

`ifdef LOADER_CHECKSUM_EN
        s = '{8'h10, 8'h01, 8'h05, 8'hEA, 8'h00, 8'h00, 8'h00};
        send(s, 1'b0);
        idle(2);
        chk("csum_mem[10]", 32'(dut_mem[8'h10]), 32'h05);
        chk("csum_done",    32'(bus.done),       32'd1);
        chk("csum_error",   32'(bus.error),      32'd0);

        do_reset();
        clear_mem();
        s = '{8'h10, 8'h01, 8'h05, 8'hEB};
        send(s, 1'b0);
        idle(3);
        chk("bad_error",    32'(bus.error),    32'd1);
        chk("bad_in_ready", 32'(bus.in_ready), 32'd0);
        chk("bad_cpu_rst",  32'(bus.cpu_rst),  32'd0);
`else
        prog = '{8'h00, 8'h05, 8'h51, 8'h81, 8'h53, 8'h80, 8'hB7,
                 8'h80, 8'h03, 8'h01, 8'h02, 8'h03,
                 8'h8B, 8'h02, 8'hF0, 8'h09,
                 8'h00, 8'h00};
        send(prog, 1'b0);
        idle(3);
        check_program();
        chk("load_done", 32'(bus.done), 32'd1);

        // Same load with in_valid toggling every cycle.
        do_reset();
        clear_mem();
        send(prog, 1'b1);
        idle(3);
        check_program();

        // Wrap-around of the write pointer.
        do_reset();
        clear_mem();
        s = '{8'hFE, 8'h03, 8'hAA, 8'hBB, 8'hCC, 8'h00, 8'h00};
        send(s, 1'b0);
        idle(2);
        chk("wrap_mem[FE]", 32'(dut_mem[8'hFE]), 32'hAA);
        chk("wrap_mem[FF]", 32'(dut_mem[8'hFF]), 32'hBB);
        chk("wrap_mem[00]", 32'(dut_mem[8'h00]), 32'hCC);
        chk("wrap_count",   32'(we_count),       32'd3);

        // Reset after 2 of 5 data bytes, then terminator.
        do_reset();
        clear_mem();
        s = '{8'h20, 8'h05, 8'h11, 8'h22};
        send(s, 1'b0);
        do_reset();
        idle(3);
        chk("abort_count",   32'(we_count),      32'd2);
        chk("abort_cpu_rst", 32'(bus.cpu_rst),   32'd0);
        s = '{8'h00, 8'h00};
        send(s, 1'b0);
        idle(2);
        chk("abort_count2",  32'(we_count),      32'd2);
        chk("abort_mem[20]", 32'(dut_mem[8'h20]), 32'h11);
        chk("abort_mem[21]", 32'(dut_mem[8'h21]), 32'h22);
        chk("abort_done",    32'(bus.cpu_rst),   32'd1);
`endif
        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
